// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the accumulator CPU fetch front end: instruction
// field widths and positions, opcode encodings and small decode helpers.
package instr_fetch_pkg;

    // Instruction word layout: [15:10] opcode, [9:0] operand.
    localparam int IW_DEF      = 16;
    localparam int AW_DEF      = 10;
    localparam int OPC_W       = 6;
    localparam int OPR_W       = 10;
    localparam int OPC_LSB     = 10;
    localparam int OPR_LSB     = 0;
    localparam int IMM_W       = 8;

    typedef logic [OPC_W-1:0] opcode_t;
    typedef logic [OPR_W-1:0] operand_t;

    // Opcode encodings shared by fetch, execute and the assembler tables.
    localparam opcode_t OP_NOP  = 6'h00;
    localparam opcode_t OP_LDCA = 6'h01;
    localparam opcode_t OP_LDCB = 6'h02;
    localparam opcode_t OP_ADDA = 6'h03;
    localparam opcode_t OP_STA  = 6'h04;
    localparam opcode_t OP_JMP  = 6'h05;

    // Opcode field of an instruction word.
    function automatic opcode_t get_opcode(input logic [IW_DEF-1:0] word);
        return word[OPC_LSB +: OPC_W];
    endfunction

    // Operand field of an instruction word.
    function automatic operand_t get_operand(input logic [IW_DEF-1:0] word);
        return word[OPR_LSB +: OPR_W];
    endfunction

    // True when the word is an unconditional jump.
    function automatic logic is_jmp(input logic [IW_DEF-1:0] word);
        return get_opcode(word) == OP_JMP;
    endfunction

endpackage

// File: rtl/fetch_next_addr.sv
// Combinational next-fetch-address selection for instr_fetch: priority mux
// (redirect > early jump > stall > sequential) plus the wrapping incrementer.
module fetch_next_addr #(
    parameter int AW = 10
) (
    input  logic          redirect_i,
    input  logic [AW-1:0] redirect_addr_i,
    input  logic          early_jmp_i,
    input  logic [AW-1:0] jmp_target_i,
    input  logic          stall_i,
    input  logic [AW-1:0] fpc_i,
    input  logic [AW-1:0] pc_i,
    output logic [AW-1:0] ip_o,
    output logic [AW-1:0] ip_inc_o
);

    // Pick the address the ROM should sample at the coming edge.
    always_comb begin
        ip_o = pc_i;
        if (redirect_i) begin
            ip_o = redirect_addr_i;
        end else if (early_jmp_i) begin
            ip_o = jmp_target_i;
        end else if (stall_i) begin
            // Re-read the presented word so Instr stays stable.
            ip_o = fpc_i;
        end
    end

    // Sequential successor; natural AW-bit overflow gives the wrap to 0.
    always_comb begin
        ip_inc_o = ip_o + {{(AW-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end of the accumulator CPU. Drives the synchronous program ROM
// address, tracks the address of the word the ROM returns one clock later,
// and presents it to execute as opcode/operand with a valid strobe.
// Optional feature macro: FETCH_EARLY_JMP_EN resolves unconditional JMP
// inside fetch with no bubble; when undefined, JMP flows to execute.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int IW = 16,
    parameter int AW = 10
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic [AW-1:0]    Ip,
    input  logic [IW-1:0]    Instr,
    input  logic             Stall,
    input  logic             Redirect,
    input  logic [AW-1:0]    RedirectAddr,
    output logic             Valid,
    output logic [OPC_W-1:0] Opcode,
    output logic [OPR_W-1:0] Operand,
    output logic [AW-1:0]    Pc
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] fpc_q;
    logic [AW-1:0] fpc_d;
    logic          fvld_q;
    logic          fvld_d;

    logic          early_jmp;
    logic [AW-1:0] jmp_target;
    logic [AW-1:0] ip_sel;
    logic [AW-1:0] ip_inc;

    assign jmp_target = Instr[AW-1:0];

`ifdef FETCH_EARLY_JMP_EN
    // A live JMP word steers the next fetch itself unless execute redirects.
    always_comb begin
        early_jmp = fvld_q & is_jmp(Instr) & ~Redirect;
    end
`else
    // JMP is presented like any other opcode; execute redirects for it.
    always_comb begin
        early_jmp = 1'b0;
    end
`endif

    fetch_next_addr #(
        .AW (AW)
    ) u_next_addr (
        .redirect_i      (Redirect),
        .redirect_addr_i (RedirectAddr),
        .early_jmp_i     (early_jmp),
        .jmp_target_i    (jmp_target),
        .stall_i         (Stall),
        .fpc_i           (fpc_q),
        .pc_i            (pc_q),
        .ip_o            (ip_sel),
        .ip_inc_o        (ip_inc)
    );

    // Next state: the presented word becomes the one just addressed. A
    // stall needs no special case because ip_sel is then fpc_q itself.
    always_comb begin
        fpc_d  = ip_sel;
        pc_d   = ip_inc;
        fvld_d = 1'b1;
    end

    // Fetch state, cleared immediately when Reset drops.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q   <= '0;
            fpc_q  <= '0;
            fvld_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            fpc_q  <= fpc_d;
            fvld_q <= fvld_d;
        end
    end

    // Outputs: address is pinned to 0 during reset so the first edge after
    // release fetches word 0; a redirect or early jump kills the word shown.
    always_comb begin
        Ip      = Reset ? ip_sel : '0;
        Valid   = fvld_q & ~Redirect & ~early_jmp;
        Opcode  = Instr[OPC_LSB +: OPC_W];
        Operand = Instr[OPR_LSB +: OPR_W];
        Pc      = fpc_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a behavioural synchronous ROM.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int IW = 16;
    localparam int AW = 10;

    logic             Clock;
    logic             Reset;
    logic [AW-1:0]    Ip;
    logic [IW-1:0]    Instr;
    logic             Stall;
    logic             Redirect;
    logic [AW-1:0]    RedirectAddr;
    logic             Valid;
    logic [OPC_W-1:0] Opcode;
    logic [OPR_W-1:0] Operand;
    logic [AW-1:0]    Pc;

    logic [IW-1:0] rom [0:(1<<AW)-1];

    int total;
    int bad;

    instr_fetch #(.IW(IW), .AW(AW)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Ip           (Ip),
        .Instr        (Instr),
        .Stall        (Stall),
        .Redirect     (Redirect),
        .RedirectAddr (RedirectAddr),
        .Valid        (Valid),
        .Opcode       (Opcode),
        .Operand      (Operand),
        .Pc           (Pc)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous ROM: data for the address sampled at the previous edge.
    always @(posedge Clock) Instr <= rom[Ip];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b1; RedirectAddr = 10'd5;
        tick(); tick();
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", Valid); end
        total++; if (Ip !== 10'd0) begin bad++; $display("FAIL reset_ip got=%0d want=0", Ip); end
        total++; if (Pc !== 10'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", Pc); end
        Redirect = 1'b0; RedirectAddr = 10'd0;
    endtask

    task automatic test_sequential();
        Reset = 1'b1;
        #1;
        total++; if (Ip !== 10'd0) begin bad++; $display("FAIL seq_first_ip got=%0d want=0", Ip); end
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL seq_first_valid got=%0b want=0", Valid); end
        tick();
        total++; if (Valid !== 1'b1 || Pc !== 10'd0 || Opcode !== OP_NOP)
            begin bad++; $display("FAIL seq_c2 got v=%0b pc=%0d op=%0h want v=1 pc=0 op=0", Valid, Pc, Opcode); end
        total++; if (Ip !== 10'd1) begin bad++; $display("FAIL seq_c2_ip got=%0d want=1", Ip); end
        tick();
        total++; if (Valid !== 1'b1 || Pc !== 10'd1 || Opcode !== OP_LDCA || Operand[7:0] !== 8'h1A)
            begin bad++; $display("FAIL seq_c3 got v=%0b pc=%0d op=%0h imm=%0h want v=1 pc=1 op=1 imm=1a", Valid, Pc, Opcode, Operand[7:0]); end
        total++; if (Ip !== 10'd2) begin bad++; $display("FAIL seq_c3_ip got=%0d want=2", Ip); end
        for (int k = 2; k <= 5; k++) begin
            tick();
            total++; if (Pc !== k[AW-1:0] || Valid !== 1'b1)
                begin bad++; $display("FAIL seq_run got pc=%0d v=%0b want pc=%0d v=1", Pc, Valid, k); end
        end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        #1;
        total++; if (Ip !== 10'd5) begin bad++; $display("FAIL stall_ip_pre got=%0d want=5", Ip); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (Pc !== 10'd5 || Valid !== 1'b1 || Opcode !== OP_LDCB || Operand[7:0] !== 8'h2C || Ip !== 10'd5)
                begin bad++; $display("FAIL stall_hold got pc=%0d v=%0b op=%0h imm=%0h ip=%0d want pc=5 v=1 op=2 imm=2c ip=5", Pc, Valid, Opcode, Operand[7:0], Ip); end
        end
        Stall = 1'b0;
        #1;
        total++; if (Ip !== 10'd6) begin bad++; $display("FAIL stall_release_ip got=%0d want=6", Ip); end
        tick();
        total++; if (Pc !== 10'd6 || Valid !== 1'b1 || Opcode !== OP_ADDA)
            begin bad++; $display("FAIL stall_after got pc=%0d v=%0b op=%0h want pc=6 v=1 op=3", Pc, Valid, Opcode); end
    endtask

    task automatic test_redirect();
        Stall = 1'b1; Redirect = 1'b1; RedirectAddr = 10'd3;
        #1;
        total++; if (Valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%0b want=0", Valid); end
        total++; if (Ip !== 10'd3) begin bad++; $display("FAIL redir_ip got=%0d want=3", Ip); end
        tick();
        Stall = 1'b0; Redirect = 1'b0; RedirectAddr = 10'd0;
        #1;
        total++; if (Pc !== 10'd3 || Valid !== 1'b1 || Opcode !== OP_STA || Operand !== 10'h011)
            begin bad++; $display("FAIL redir_target got pc=%0d v=%0b op=%0h opr=%0h want pc=3 v=1 op=4 opr=11", Pc, Valid, Opcode, Operand); end
        total++; if (Ip !== 10'd4) begin bad++; $display("FAIL redir_next_ip got=%0d want=4", Ip); end
    endtask

    task automatic test_jmp();
        Redirect = 1'b1; RedirectAddr = 10'd16;
        tick();
        Redirect = 1'b0;
        #1;
        total++; if (Pc !== 10'd16 || Valid !== 1'b1 || Ip !== 10'd17)
            begin bad++; $display("FAIL jmp_pre got pc=%0d v=%0b ip=%0d want pc=16 v=1 ip=17", Pc, Valid, Ip); end
        tick();
`ifdef FETCH_EARLY_JMP_EN
        total++; if (Valid !== 1'b0 || Ip !== 10'd3)
            begin bad++; $display("FAIL jmp_early got v=%0b ip=%0d want v=0 ip=3", Valid, Ip); end
        tick();
        total++; if (Pc !== 10'd3 || Valid !== 1'b1)
            begin bad++; $display("FAIL jmp_early_target got pc=%0d v=%0b want pc=3 v=1", Pc, Valid); end
`else
        total++; if (Valid !== 1'b1 || Pc !== 10'd17 || Opcode !== OP_JMP || Operand !== 10'd3 || Ip !== 10'd18)
            begin bad++; $display("FAIL jmp_shown got v=%0b pc=%0d op=%0h opr=%0d ip=%0d want v=1 pc=17 op=5 opr=3 ip=18", Valid, Pc, Opcode, Operand, Ip); end
        tick();
        Redirect = 1'b1; RedirectAddr = 10'd3;
        #1;
        total++; if (Valid !== 1'b0 || Ip !== 10'd3)
            begin bad++; $display("FAIL jmp_kill got v=%0b ip=%0d want v=0 ip=3", Valid, Ip); end
        tick();
        Redirect = 1'b0;
        #1;
        total++; if (Pc !== 10'd3 || Valid !== 1'b1)
            begin bad++; $display("FAIL jmp_target got pc=%0d v=%0b want pc=3 v=1", Pc, Valid); end
`endif
    endtask

    task automatic test_wrap();
        Redirect = 1'b1; RedirectAddr = 10'd1022;
        tick();
        Redirect = 1'b0;
        #1;
        total++; if (Pc !== 10'd1022 || Ip !== 10'd1023)
            begin bad++; $display("FAIL wrap_1022 got pc=%0d ip=%0d want pc=1022 ip=1023", Pc, Ip); end
        tick();
        total++; if (Pc !== 10'd1023 || Ip !== 10'd0)
            begin bad++; $display("FAIL wrap_1023 got pc=%0d ip=%0d want pc=1023 ip=0", Pc, Ip); end
        tick();
        total++; if (Pc !== 10'd0 || Valid !== 1'b1 || Ip !== 10'd1)
            begin bad++; $display("FAIL wrap_0 got pc=%0d v=%0b ip=%0d want pc=0 v=1 ip=1", Pc, Valid, Ip); end
    endtask

    task automatic test_async_reset();
        Redirect = 1'b1; RedirectAddr = 10'd8;
        tick();
        Redirect = 1'b0;
        tick();
        total++; if (Pc !== 10'd9 || Valid !== 1'b1)
            begin bad++; $display("FAIL areset_pre got pc=%0d v=%0b want pc=9 v=1", Pc, Valid); end
        #2;
        Reset = 1'b0;
        #1;
        total++; if (Valid !== 1'b0 || Ip !== 10'd0 || Pc !== 10'd0)
            begin bad++; $display("FAIL areset_async got v=%0b ip=%0d pc=%0d want v=0 ip=0 pc=0", Valid, Ip, Pc); end
        tick();
        total++; if (Valid !== 1'b0 || Ip !== 10'd0)
            begin bad++; $display("FAIL areset_hold got v=%0b ip=%0d want v=0 ip=0", Valid, Ip); end
        Reset = 1'b1;
        tick();
        total++; if (Valid !== 1'b1 || Pc !== 10'd0 || Ip !== 10'd1)
            begin bad++; $display("FAIL areset_refetch got v=%0b pc=%0d ip=%0d want v=1 pc=0 ip=1", Valid, Pc, Ip); end
        tick();
        total++; if (Pc !== 10'd1 || Opcode !== OP_LDCA)
            begin bad++; $display("FAIL areset_next got pc=%0d op=%0h want pc=1 op=1", Pc, Opcode); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int a = 0; a < (1 << AW); a++) rom[a] = {OP_NOP, 10'h000};
        rom[1]  = {OP_LDCA, 10'h01A};
        rom[3]  = {OP_STA,  10'h011};
        rom[5]  = {OP_LDCB, 10'h02C};
        rom[6]  = {OP_ADDA, 10'h007};
        rom[16] = {OP_LDCA, 10'h055};
        rom[17] = {OP_JMP,  10'd3};
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectAddr = '0;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_jmp();
        test_wrap();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
